predict_pipe: RTL and testbench

PREDICT_PIPE -- requirements
Module: predict_pipe

---
 rtl/predict_pipe_pkg.sv | 13 +
 rtl/predict_lane.sv | 35 +++
 rtl/predict_pipe.sv | 83 ++++++++
 tb/tb_predict_pipe.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/predict_pipe_pkg.sv
// Shared types and default widths for the prediction pipeline.
// Activation selector encoding and the fixed-point defaults live here.
package Common;
    typedef enum logic [1:0] {
        Identity       = 2'd0,
        Heaviside_Step = 2'd1,
        ReLU           = 2'd2,
        Leaky_ReLU     = 2'd3
    } act_func;

    localparam int DEF_W    = 16;
    localparam int DEF_FRAC = 8;
endpackage

// File: rtl/predict_lane.sv
// One channel's activation function, purely combinational.
// Results stay within W bits: every branch is sum, a shifted sum, 0, 1.0 or CLIP_MAX.
module predict_lane
    import Common::*;
#(
    parameter int W          = DEF_W,
    parameter int FRAC       = DEF_FRAC,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_EN    = 0,
    parameter int CLIP_MAX   = 6 << FRAC
) (
    input  act_func              act,
    input  logic signed [W-1:0]  sum,
    output logic signed [W-1:0]  pred
);
    localparam logic signed [W-1:0] ONE    = W'(1 << FRAC);
    localparam logic signed [W-1:0] CLIP_V = W'(CLIP_MAX);

    logic               is_pos;
    logic signed [W-1:0] pos_v;

    always_comb begin
        is_pos = !sum[W-1] && (sum != '0);
        pos_v  = sum;
        if (CLIP_EN != 0 && sum > CLIP_V)
            pos_v = CLIP_V;
        pred = '0;
        case (act)
            Identity:       pred = sum;
            Heaviside_Step: pred = is_pos ? ONE : '0;
            ReLU:           pred = is_pos ? pos_v : '0;
            Leaky_ReLU:     pred = sum[W-1] ? (sum >>> LEAK_SHIFT) : pos_v;
        endcase
    end
endmodule

// File: rtl/predict_pipe.sv
// Two-stage activation pipeline: S1 holds sum/activation, S2 holds per-channel results.
// Valid/ready handshake on both sides; a stalled S2 back-pressures through S1.
module predict_pipe
    import Common::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = DEF_W,
    parameter int FRAC       = DEF_FRAC,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_EN    = 0,
    parameter int CLIP_MAX   = 6 << FRAC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  act_func           activation,
    input  logic [N_CH*W-1:0] sum,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_CH*W-1:0] prediction,
    output logic              out_valid,
    input  logic              out_ready
);
    if (FRAC >= W - 1) begin : g_bad_frac
        $error("predict_pipe: FRAC must be less than W-1");
    end

    logic [2:1]                vld_pipe_q, vld_pipe_d;
    logic [N_CH-1:0][W-1:0]    s1_sum_q, s1_sum_d;
    act_func                   s1_act_q, s1_act_d;
    logic [N_CH-1:0][W-1:0]    s2_pred_q, s2_pred_d;
    logic [N_CH-1:0][W-1:0]    sum_v, lane_out;
    logic                      stall, s1_en;

    assign sum_v      = sum;
    assign stall      = vld_pipe_q[2] && !out_ready;
    assign s1_en      = !vld_pipe_q[1] || !stall;
    assign in_ready   = s1_en;
    assign out_valid  = vld_pipe_q[2];
    assign prediction = s2_pred_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        predict_lane #(
            .W(W), .FRAC(FRAC), .LEAK_SHIFT(LEAK_SHIFT),
            .CLIP_EN(CLIP_EN), .CLIP_MAX(CLIP_MAX)
        ) u_lane (
            .act  (s1_act_q),
            .sum  (s1_sum_q[g]),
            .pred (lane_out[g])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_sum_d   = s1_sum_q;
        s1_act_d   = s1_act_q;
        s2_pred_d  = s2_pred_q;
        if (s1_en) begin
            vld_pipe_d[1] = in_valid;
            if (in_valid) begin
                s1_sum_d = sum_v;
                s1_act_d = activation;
            end
        end
        if (!stall) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            s2_pred_d     = lane_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_sum_q   <= '0;
            s1_act_q   <= Identity;
            s2_pred_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_sum_q   <= s1_sum_d;
            s1_act_q   <= s1_act_d;
            s2_pred_q  <= s2_pred_d;
        end
    end
endmodule

// File: tb/tb_predict_pipe.sv
// Bench for predict_pipe: a default instance and a clipping instance share stimulus,
// each with its own expected-result queue.
module tb_predict_pipe;
    import Common::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    act_func     activation = Identity;
    logic [63:0] sum = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, in_ready_c, out_valid_c;
    logic [63:0] prediction, prediction_c;

    always #5 clk = ~clk;

    predict_pipe #(.N_CH(4), .W(16), .FRAC(8), .LEAK_SHIFT(3), .CLIP_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .activation(activation), .sum(sum),
        .in_valid(in_valid), .in_ready(in_ready), .prediction(prediction),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    predict_pipe #(.N_CH(4), .W(16), .FRAC(8), .LEAK_SHIFT(3), .CLIP_EN(1),
                   .CLIP_MAX(16'h0600)) dut_c (
        .clk(clk), .rst_n(rst_n), .activation(activation), .sum(sum),
        .in_valid(in_valid), .in_ready(in_ready_c), .prediction(prediction_c),
        .out_valid(out_valid_c), .out_ready(out_ready)
    );

    typedef struct {
        act_func     act;
        logic [63:0] sum;
        logic [63:0] exp;
        logic [63:0] expc;
    } vec_t;

    vec_t        tbl [8];
    logic [63:0] q[$], qc[$];
    logic [63:0] cur_exp, cur_expc, held;
    int          nvec = 0, nfail = 0, n_out = 0;
    logic        in_ready_s, stalled_s, in_fire_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int i);
        activation = tbl[i].act;
        sum        = tbl[i].sum;
        cur_exp    = tbl[i].exp;
        cur_expc   = tbl[i].expc;
        in_valid   = 1'b1;
    endtask

    // Handshakes are sampled mid-cycle, then the clock edge is taken.
    task automatic cycle();
        logic in_fire, out_fire, out_fire_c;
        #1;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        out_fire_c = out_valid_c && out_ready;
        in_ready_s = in_ready;
        in_fire_s  = in_fire;
        stalled_s  = out_valid && !out_ready;
        held       = prediction;
        if (out_fire) begin
            if (q.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL stale_beat: got %h, expected no beat", prediction);
            end else begin
                chk("prediction", prediction, q.pop_front());
                n_out++;
            end
        end
        if (out_fire_c) begin
            if (qc.size() == 0) begin
                nvec++; nfail++;
                $display("FAIL stale_beat_clip: got %h, expected no beat", prediction_c);
            end else begin
                chk("prediction_clip", prediction_c, qc.pop_front());
            end
        end
        if (in_fire) begin
            q.push_back(cur_exp);
            qc.push_back(cur_expc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (q.size() != 0 || qc.size() != 0); k++)
            cycle();
        if (q.size() != 0 || qc.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size() + qc.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_block;

        tbl[0] = '{ReLU,           64'h7FFF_0000_FF00_0100, 64'h7FFF_0000_0000_0100, 64'h0600_0000_0000_0100};
        tbl[1] = '{Leaky_ReLU,     64'h0010_8000_FFF9_FFF8, 64'h0010_F000_FFFF_FFFF, 64'h0010_F000_FFFF_FFFF};
        tbl[2] = '{Heaviside_Step, 64'h7FFF_FFFF_0000_0001, 64'h0100_0000_0000_0100, 64'h0100_0000_0000_0100};
        tbl[3] = '{ReLU,           64'hFFFF_0601_0600_0700, 64'h0000_0601_0600_0700, 64'h0000_0600_0600_0600};
        tbl[4] = '{Identity,       64'h0000_7FFF_8000_0700, 64'h0000_7FFF_8000_0700, 64'h0000_7FFF_8000_0700};
        tbl[5] = '{Leaky_ReLU,     64'hFFF0_FFFF_0000_7000, 64'hFFFE_FFFF_0000_7000, 64'hFFFE_FFFF_0000_0600};
        tbl[6] = '{Heaviside_Step, 64'hFF00_0002_0100_8000, 64'h0000_0100_0100_0000, 64'h0000_0100_0100_0000};
        tbl[7] = '{Identity,       64'hFFFF_0001_FEDC_1234, 64'hFFFF_0001_FEDC_1234, 64'hFFFF_0001_FEDC_1234};

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prediction", prediction, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid_clip", out_valid_c, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single beats: latency of two edges, then value check
        for (int i = 0; i < 8; i++) begin
            set_beat(i);
            #1;
            chk("in_ready_idle", in_ready, 1);
            cycle();
            in_valid = 1'b0;
            chk("lat_k1_out_valid", out_valid, 0);
            cycle();
            chk("lat_k2_out_valid", out_valid, 1);
            drain();
        end

        // Back-to-back beats with out_ready low for cycles 3-5
        n_out = 0;
        saw_block = 1'b0;
        stalled_s = 1'b0;
        for (int cyc = 1, bi = 0; cyc <= 12; cyc++) begin
            if (stalled_s && out_valid)
                chk("hold_prediction", prediction, held);
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (bi < 4) set_beat(4 + bi);
            else in_valid = 1'b0;
            cycle();
            if (in_fire_s) bi++;
            if (!in_ready_s) saw_block = 1'b1;
            if (cyc == 2) chk("b2b_in_ready_c2", in_ready_s, 1);
            if (cyc == 3) chk("b2b_in_ready_full", in_ready_s, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("b2b_blocked_seen", saw_block, 1);
        chk("b2b_beat_count", n_out, 4);

        // Reset with two beats in flight
        out_ready = 1'b0;
        set_beat(0); cycle();
        set_beat(1); cycle();
        in_valid = 1'b0;
        chk("inflight_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_prediction", prediction, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid_clip", out_valid_c, 0);
        q.delete();
        qc.delete();
        @(posedge clk); #1;
        chk("inrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("postrst_no_stale", out_valid, 0);
        end
        n_out = 0;
        set_beat(2);
        #1;
        chk("postrst_in_ready", in_ready, 1);
        cycle();
        in_valid = 1'b0;
        drain();
        chk("postrst_beat_count", n_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
